// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between two requesters.
// Registers the winning op, holds it ALU_LATENCY cycles, captures the result and pulses the winner's response.
module alu_share_arbiter #(
    parameter int WIDTH       = 16,
    parameter int OPW         = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic       grant;
    logic [3:0] cnt;
    logic       accept;

    // last_grant==1 means requester 0 wins the next tie.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            req0_ready = req0_valid && (!req1_valid || last_grant);
            req1_ready = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign accept = req0_ready || req1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            cnt           <= 4'd0;
            alu_op        <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            resp_result   <= '0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant      <= req1_ready;
                        last_grant <= req1_ready;
                        cnt        <= CNT_LOAD;
                        alu_op     <= req1_ready ? req1_op : req0_op;
                        alu_a      <= req1_ready ? req1_a  : req0_a;
                        alu_b      <= req1_ready ? req1_b  : req0_b;
                    end
                end
                ISSUE: begin
                    // Operands stay put while the ALU settles; sample once the count runs out.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_result   <= alu_result;
                        resp_zero     <= alu_zero;
                        resp_overflow <= alu_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign resp0_valid = (state == RESP) && !grant;
    assign resp1_valid = (state == RESP) && grant;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (latency 1 and 3) driven from shared requests,
// each fed by a behavioural ALU, checked against a transaction-level arbitration model.
module tb_alu_share_arbiter;
    localparam int L1 = 1;
    localparam int L3 = 3;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd5;

    typedef struct {
        int          when;
        int          port;
        logic [15:0] res;
        logic        z;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic        r0v = 1'b0, r1v = 1'b0;
    logic [3:0]  r0op = '0, r1op = '0;
    logic [15:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;

    logic        rdy0_1, rdy1_1, rsp0_1, rsp1_1, z_1, ov_1, busy_1, alu_z_1, alu_ov_1;
    logic [3:0]  aop_1;
    logic [15:0] res_1, aa_1, ab_1, alu_res_1;
    logic        rdy0_3, rdy1_3, rsp0_3, rsp1_3, z_3, ov_3, busy_3, alu_z_3, alu_ov_3;
    logic [3:0]  aop_3;
    logic [15:0] res_3, aa_3, ab_3, alu_res_3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: returns {overflow, result}; SLT corrects the sign with overflow.
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic        v;
        s = '0;
        v = 1'b0;
        case (op)
            4'd0: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
            4'd1: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
            4'd2: s = a & b;
            4'd3: s = a | b;
            4'd4: s = a ^ b;
            4'd5: begin
                s = a - b;
                v = (a[15] != b[15]) && (s[15] != a[15]);
                s = {15'd0, s[15] ^ v};
            end
            default: s = a;
        endcase
        return {v, s};
    endfunction

    always_comb begin
        {alu_ov_1, alu_res_1} = alu_f(aop_1, aa_1, ab_1);
        alu_z_1 = (alu_res_1 == 16'd0);
        {alu_ov_3, alu_res_3} = alu_f(aop_3, aa_3, ab_3);
        alu_z_3 = (alu_res_3 == 16'd0);
    end

    alu_share_arbiter #(.WIDTH(16), .OPW(4), .ALU_LATENCY(L1)) dut1 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_ready(rdy0_1),
        .req1_valid(r1v), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_ready(rdy1_1),
        .resp0_valid(rsp0_1), .resp1_valid(rsp1_1), .resp_result(res_1), .resp_zero(z_1),
        .resp_overflow(ov_1), .alu_op(aop_1), .alu_a(aa_1), .alu_b(ab_1),
        .alu_result(alu_res_1), .alu_zero(alu_z_1), .alu_overflow(alu_ov_1), .busy(busy_1)
    );

    alu_share_arbiter #(.WIDTH(16), .OPW(4), .ALU_LATENCY(L3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_ready(rdy0_3),
        .req1_valid(r1v), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_ready(rdy1_3),
        .resp0_valid(rsp0_3), .resp1_valid(rsp1_3), .resp_result(res_3), .resp_zero(z_3),
        .resp_overflow(ov_3), .alu_op(aop_3), .alu_a(aa_3), .alu_b(ab_3),
        .alu_result(alu_res_3), .alu_zero(alu_z_3), .alu_overflow(alu_ov_3), .busy(busy_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        r0v = 1'b0; r1v = 1'b0;
        r0op = '0; r1op = '0; r0a = '0; r0b = '0; r1a = '0; r1b = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_req(input int port);
        if (port == 0) begin
            r0op = 4'($urandom_range(0, 5)); r0a = 16'($urandom); r0b = 16'($urandom);
        end else begin
            r1op = 4'($urandom_range(0, 5)); r1a = 16'($urandom); r1b = 16'($urandom);
        end
    endtask

    // Drives one request on dut1 and reports the port/result of the first response pulse (port -1 on timeout).
    task automatic transact(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            output int rport, output logic [15:0] res, output logic z, output logic ov);
        int acc;
        acc = 0; rport = -1; res = '0; z = 1'b0; ov = 1'b0;
        if (port == 0) begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; end
        else           begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; end
        #1;
        for (int i = 0; i < 20 && acc == 0; i++) begin
            if ((port == 0 && rdy0_1 === 1'b1) || (port == 1 && rdy1_1 === 1'b1)) acc = 1;
            tick();
        end
        r0v = 1'b0; r1v = 1'b0;
        if (acc == 0) return;
        for (int i = 0; i < 20 && rport < 0; i++) begin
            if (rsp0_1 === 1'b1) rport = 0;
            else if (rsp1_1 === 1'b1) rport = 1;
            if (rport >= 0) begin res = res_1; z = z_1; ov = ov_1; end
            else tick();
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        reset = 1'b1;
        #1;
        checks++; if (busy_1 !== 1'b0 || busy_3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", busy_1, busy_3); end
        checks++; if ({rsp0_1, rsp1_1, rdy0_1, rdy1_1} !== 4'b0) begin errors++; $display("FAIL reset_handshake: got %b want 0000", {rsp0_1, rsp1_1, rdy0_1, rdy1_1}); end
        checks++; if ({res_1, z_1, ov_1} !== 18'd0) begin errors++; $display("FAIL reset_resp: got %h want 0", {res_1, z_1, ov_1}); end
        checks++; if ({aop_1, aa_1, ab_1} !== 36'd0) begin errors++; $display("FAIL reset_alu_regs: got %h want 0", {aop_1, aa_1, ab_1}); end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        r0v = 1'b1; r0op = OP_ADD; r0a = 16'h0005; r0b = 16'h0003;
        #1;
        checks++; if (rdy0_1 !== 1'b1 || rdy1_1 !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b%b want 10", rdy0_1, rdy1_1); end
        tick();
        r0v = 1'b0;
        checks++; if (busy_1 !== 1'b1 || aa_1 !== 16'h0005 || ab_1 !== 16'h0003 || rsp0_1 !== 1'b0) begin
            errors++; $display("FAIL basic_issue: got busy=%b a=%h b=%h resp0=%b want 1 0005 0003 0", busy_1, aa_1, ab_1, rsp0_1);
        end
        tick();
        checks++; if (rsp0_1 !== 1'b1 || rsp1_1 !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b%b want 10", rsp0_1, rsp1_1); end
        checks++; if (res_1 !== 16'h0008 || z_1 !== 1'b0) begin errors++; $display("FAIL basic_result: got %h z=%b want 0008 z=0", res_1, z_1); end
        tick();
        checks++; if (rsp0_1 !== 1'b0 || busy_1 !== 1'b0 || res_1 !== 16'h0008) begin
            errors++; $display("FAIL basic_after: got resp0=%b busy=%b res=%h want 0 0 0008", rsp0_1, busy_1, res_1);
        end
    endtask

    task automatic test_slt();
        int p; logic [15:0] r; logic z, o;
        do_reset();
        transact(0, OP_SLT, 16'h8000, 16'h0001, p, r, z, o);
        checks++; if (p != 0 || r !== 16'h0001 || o !== 1'b1) begin errors++; $display("FAIL slt_neg_pos: got port=%0d r=%h ov=%b want 0 0001 1", p, r, o); end
        tick();
        transact(0, OP_SLT, 16'h0001, 16'h8000, p, r, z, o);
        checks++; if (p != 0 || r !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL slt_pos_neg: got port=%0d r=%h z=%b want 0 0000 1", p, r, z); end
        tick();
        transact(1, OP_ADD, 16'h7fff, 16'h0001, p, r, z, o);
        checks++; if (p != 1 || r !== 16'h8000 || o !== 1'b1) begin errors++; $display("FAIL add_ovf_port1: got port=%0d r=%h ov=%b want 1 8000 1", p, r, o); end
        tick();
    endtask

    task automatic test_round_robin();
        exp_t q[$]; exp_t e; logic [16:0] f;
        int grants, nresp, g, want;
        do_reset();
        grants = 0; nresp = 0;
        r0v = 1'b1; r1v = 1'b1; rand_req(0); rand_req(1);
        #1;
        for (int i = 0; i < 60 && nresp < 4; i++) begin
            if (rsp0_1 === 1'b1 || rsp1_1 === 1'b1) begin
                e = q.pop_front();
                nresp++;
                checks++; if (rsp0_1 !== (e.port == 0) || rsp1_1 !== (e.port == 1) || res_1 !== e.res) begin
                    errors++; $display("FAIL rr_resp: got %b%b res=%h want port %0d res=%h", rsp0_1, rsp1_1, res_1, e.port, e.res);
                end
            end
            g = -1;
            if (grants < 4 && (rdy0_1 === 1'b1 || rdy1_1 === 1'b1)) begin
                g = (rdy0_1 === 1'b1) ? 0 : 1;
                want = grants % 2;
                checks++; if (g != want || (rdy0_1 && rdy1_1)) begin
                    errors++; $display("FAIL rr_grant: got ready=%b%b want grant %0d", rdy0_1, rdy1_1, want);
                end
                f = (g == 0) ? alu_f(r0op, r0a, r0b) : alu_f(r1op, r1a, r1b);
                e.when = 0; e.port = g; e.res = f[15:0]; e.z = (f[15:0] == 16'd0); e.ov = f[16];
                q.push_back(e);
                grants++;
            end
            tick();
            if (g >= 0) begin
                if (grants == 4) begin r0v = 1'b0; r1v = 1'b0; end
                else rand_req(g);
            end
            #1;
        end
        r0v = 1'b0; r1v = 1'b0;
        checks++; if (nresp != 4) begin errors++; $display("FAIL rr_count: got %0d responses want 4", nresp); end
    endtask

    task automatic test_back_to_back();
        exp_t q[$]; exp_t e; logic [16:0] f;
        int at[4]; int na, nr, pend;
        do_reset();
        na = 0; nr = 0;
        r1v = 1'b1; rand_req(1);
        #1;
        for (int i = 0; i < 60 && nr < 4; i++) begin
            if (rsp0_1 === 1'b1 || rsp1_1 === 1'b1) begin
                e = q.pop_front();
                nr++;
                checks++; if (rsp1_1 !== 1'b1 || rsp0_1 !== 1'b0 || res_1 !== e.res || z_1 !== e.z) begin
                    errors++; $display("FAIL b2b_resp: got %b%b res=%h z=%b want 01 res=%h z=%b", rsp0_1, rsp1_1, res_1, z_1, e.res, e.z);
                end
            end
            pend = 0;
            if (na < 4 && rdy1_1 === 1'b1) begin
                at[na] = cyc + 1;
                f = alu_f(r1op, r1a, r1b);
                e.when = 0; e.port = 1; e.res = f[15:0]; e.z = (f[15:0] == 16'd0); e.ov = f[16];
                q.push_back(e);
                na++;
                pend = 1;
            end
            tick();
            if (pend == 1) begin
                if (na == 4) r1v = 1'b0;
                else rand_req(1);
            end
            #1;
        end
        r1v = 1'b0;
        checks++; if (nr != 4) begin errors++; $display("FAIL b2b_count: got %0d responses want 4", nr); end
        for (int k = 1; k < 4; k++) begin
            if (k < na) begin
                checks++; if (at[k] - at[k-1] != L1 + 2) begin
                    errors++; $display("FAIL b2b_interval: got %0d cycles want %0d", at[k] - at[k-1], L1 + 2);
                end
            end
        end
    endtask

    // Requests appear randomly; the model predicts every ready and response from the arbitration rules.
    task automatic test_random();
        exp_t q[$]; exp_t e; logic [16:0] f;
        int g, last, free_at;
        do_reset();
        last = 1; free_at = 0;
        for (int i = 0; i < 160; i++) begin
            if (q.size() > 0 && q[0].when == cyc) begin
                e = q.pop_front();
                checks++; if (rsp0_1 !== (e.port == 0) || rsp1_1 !== (e.port == 1) ||
                              {res_1, z_1, ov_1} !== {e.res, e.z, e.ov}) begin
                    errors++; $display("FAIL rand_resp: got %b%b %h/%b/%b want port %0d %h/%b/%b",
                                       rsp0_1, rsp1_1, res_1, z_1, ov_1, e.port, e.res, e.z, e.ov);
                end
            end else begin
                checks++; if (rsp0_1 !== 1'b0 || rsp1_1 !== 1'b0) begin
                    errors++; $display("FAIL rand_spurious: got %b%b want 00", rsp0_1, rsp1_1);
                end
            end
            if (i < 140) begin
                if (!r0v && $urandom_range(0, 1) == 1) begin r0v = 1'b1; rand_req(0); end
                if (!r1v && $urandom_range(0, 1) == 1) begin r1v = 1'b1; rand_req(1); end
            end
            #1;
            g = -1;
            if (cyc + 1 >= free_at) begin
                if (r0v && (!r1v || last == 1)) g = 0;
                else if (r1v) g = 1;
            end
            checks++; if (rdy0_1 !== (g == 0) || rdy1_1 !== (g == 1)) begin
                errors++; $display("FAIL rand_ready: got %b%b want grant %0d", rdy0_1, rdy1_1, g);
            end
            if (g >= 0) begin
                f = (g == 0) ? alu_f(r0op, r0a, r0b) : alu_f(r1op, r1a, r1b);
                e.when = cyc + 1 + L1; e.port = g; e.res = f[15:0]; e.z = (f[15:0] == 16'd0); e.ov = f[16];
                q.push_back(e);
                last = g;
                free_at = cyc + 1 + L1 + 2;
            end
            tick();
            if (g == 0) r0v = 1'b0;
            if (g == 1) r1v = 1'b0;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d outstanding want 0", q.size()); end
        clear_reqs();
    endtask

    task automatic test_latency3();
        int acc;
        do_reset();
        acc = 0;
        r0v = 1'b1; r0op = OP_SUB; r0a = 16'h0004; r0b = 16'h0004;
        #1;
        for (int i = 0; i < 10 && acc == 0; i++) begin
            if (rdy0_3 === 1'b1) acc = 1;
            tick();
        end
        checks++; if (acc == 0) begin errors++; $display("FAIL lat3_accept: got no ready want ready"); end
        r0v = 1'b0; r0a = 16'h1234; r0b = 16'h0007; r0op = OP_ADD;
        for (int k = 0; k < L3; k++) begin
            checks++; if (aa_3 !== 16'h0004 || ab_3 !== 16'h0004 || aop_3 !== OP_SUB || rsp0_3 !== 1'b0) begin
                errors++; $display("FAIL lat3_hold: got a=%h b=%h op=%h resp0=%b want 0004 0004 1 0", aa_3, ab_3, aop_3, rsp0_3);
            end
            tick();
        end
        checks++; if (rsp0_3 !== 1'b1 || rsp1_3 !== 1'b0 || res_3 !== 16'h0000 || z_3 !== 1'b1) begin
            errors++; $display("FAIL lat3_resp: got %b%b res=%h z=%b want 10 0000 1", rsp0_3, rsp1_3, res_3, z_3);
        end
        tick();
        checks++; if (rsp0_3 !== 1'b0 || busy_3 !== 1'b0) begin errors++; $display("FAIL lat3_end: got resp0=%b busy=%b want 0 0", rsp0_3, busy_3); end
    endtask

    task automatic test_reset_mid();
        int acc, pulses;
        do_reset();
        acc = 0; pulses = 0;
        r1v = 1'b1; r1op = OP_ADD; r1a = 16'h0001; r1b = 16'h0002;
        #1;
        for (int i = 0; i < 10 && acc == 0; i++) begin
            if (rdy1_3 === 1'b1) acc = 1;
            tick();
        end
        r1v = 1'b0;
        tick();
        checks++; if (busy_3 !== 1'b1 || acc == 0) begin errors++; $display("FAIL mid_inflight: got busy=%b want 1", busy_3); end
        reset = 1'b1;
        #1;
        checks++; if (busy_3 !== 1'b0 || {aop_3, aa_3, ab_3} !== 36'd0 || {res_3, z_3, ov_3, rsp0_3, rsp1_3} !== 20'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got busy=%b alu=%h resp=%h want 0", busy_3, {aop_3, aa_3, ab_3}, {res_3, z_3, ov_3, rsp0_3, rsp1_3});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp0_3 === 1'b1 || rsp1_3 === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses want 0", pulses); end
        r0v = 1'b1; r0op = OP_SUB; r0a = 16'h0009; r0b = 16'h0004;
        r1v = 1'b1; r1op = OP_ADD; r1a = 16'h0100; r1b = 16'h0100;
        #1;
        checks++; if (rdy0_3 !== 1'b1 || rdy1_3 !== 1'b0) begin errors++; $display("FAIL mid_tie_after_reset: got %b%b want 10", rdy0_3, rdy1_3); end
        tick();
        r0v = 1'b0; r1v = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (rsp0_3 !== 1'b1 || rsp1_3 !== 1'b0 || res_3 !== 16'h0005) begin
            errors++; $display("FAIL mid_next_op: got %b%b res=%h want 10 0005", rsp0_3, rsp1_3, res_3);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_reqs();
        test_reset();
        test_basic();
        test_slt();
        test_round_robin();
        test_back_to_back();
        test_random();
        test_latency3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
